// File: rtl/rom_load_ctrl_if.sv
// Signal bundle between the HPS download port, the ROM loader and the game core.
// The master drives the ioctl side; the loader is the slave.
interface rom_load_ctrl_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        user_reset;

   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic [1:0]  dn_region;
   logic        core_reset;
   logic        rom_valid;
   logic        load_err;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset,
      input  dn_addr, dn_data, dn_wr, dn_region, core_reset, rom_valid, load_err
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset,
      output dn_addr, dn_data, dn_wr, dn_region, core_reset, rom_valid, load_err
   );
endinterface

// File: rtl/rom_load_ctrl.sv
// ROM download controller: forwards HPS bytes into ROM, checks the image length,
// and sequences the game core reset around loads and user resets.
module rom_load_ctrl #(
   parameter logic [16:0] EXPECTED_LEN = 17'h10000,
   parameter logic [15:0] RESET_HOLD   = 16'd1024,
   parameter logic [15:0] GFX_BASE     = 16'h4000,
   parameter logic [15:0] SND_BASE     = 16'h5000
) (
   input  logic           clk_sys,
   input  logic           RESET,
   rom_load_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   localparam logic [1:0] REG_CPU   = 2'd0;
   localparam logic [1:0] REG_GFX   = 2'd1;
   localparam logic [1:0] REG_OTHER = 2'd2;

   localparam logic [16:0] COUNT_MAX = 17'h1FFFF;

   logic [2:0]  state_q, state_d;
   logic        dl_q, dl_d;
   logic [16:0] count_q, count_d;
   logic        ovf_q, ovf_d;
   logic [15:0] hold_q, hold_d;
   logic        rom_valid_q, rom_valid_d;
   logic        load_err_q, load_err_d;
   logic        core_reset_q, core_reset_d;
   logic        dn_wr_q, dn_wr_d;
   logic [15:0] dn_addr_q, dn_addr_d;
   logic [7:0]  dn_data_q, dn_data_d;
   logic [1:0]  dn_region_q, dn_region_d;

   logic dl_rise, dl_fall, rise_go, wr_live, in_range, wr_accept, wr_drop;

   always_comb begin
      dl_rise   = bus.ioctl_download & ~dl_q;
      dl_fall   = ~bus.ioctl_download & dl_q;
      // A rise seen in CHECK is a glitch right after a fall; it does not start a load.
      rise_go   = dl_rise && (state_q != S_CHECK);
      wr_live   = bus.ioctl_wr && bus.ioctl_download && (rise_go || state_q == S_LOAD);
      in_range  = bus.ioctl_addr < {8'd0, EXPECTED_LEN};
      wr_accept = wr_live && in_range;
      wr_drop   = wr_live && !in_range;
   end

   always_comb begin
      state_d     = state_q;
      dl_d        = bus.ioctl_download;
      count_d     = count_q;
      ovf_d       = ovf_q;
      hold_d      = hold_q;
      rom_valid_d = rom_valid_q;
      load_err_d  = load_err_q;

      if (rise_go) begin
         state_d     = S_LOAD;
         count_d     = wr_accept ? 17'd1 : 17'd0;
         ovf_d       = wr_drop;
         rom_valid_d = 1'b0;
         load_err_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ERROR: ;
            S_LOAD: begin
               if (wr_accept && count_q != COUNT_MAX)
                  count_d = count_q + 17'd1;
               if (wr_drop)
                  ovf_d = 1'b1;
               if (dl_fall)
                  state_d = S_CHECK;
            end
            S_CHECK: begin
               if (count_q == EXPECTED_LEN && !ovf_q) begin
                  state_d     = S_HOLD;
                  hold_d      = RESET_HOLD;
                  rom_valid_d = 1'b1;
               end else begin
                  state_d    = S_ERROR;
                  load_err_d = 1'b1;
               end
            end
            S_HOLD: begin
               // RUN follows the cycle after the counter has reached zero.
               if (bus.user_reset)
                  hold_d = RESET_HOLD;
               else if (hold_q == 16'd0)
                  state_d = S_RUN;
               else
                  hold_d = hold_q - 16'd1;
            end
            S_RUN: begin
               if (bus.user_reset) begin
                  state_d = S_HOLD;
                  hold_d  = RESET_HOLD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      dn_wr_d     = wr_accept;
      dn_addr_d   = dn_addr_q;
      dn_data_d   = dn_data_q;
      dn_region_d = dn_region_q;
      if (wr_accept) begin
         dn_addr_d = bus.ioctl_addr[15:0];
         dn_data_d = bus.ioctl_dout;
         if (bus.ioctl_addr < {9'd0, GFX_BASE})
            dn_region_d = REG_CPU;
         else if (bus.ioctl_addr < {9'd0, SND_BASE})
            dn_region_d = REG_GFX;
         else
            dn_region_d = REG_OTHER;
      end
      core_reset_d = (state_d != S_RUN);
   end

   // dl_q resets high so a download still active across RESET is not seen as a new edge.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         dl_q         <= 1'b1;
         count_q      <= 17'd0;
         ovf_q        <= 1'b0;
         hold_q       <= 16'd0;
         rom_valid_q  <= 1'b0;
         load_err_q   <= 1'b0;
         core_reset_q <= 1'b1;
         dn_wr_q      <= 1'b0;
         dn_addr_q    <= 16'd0;
         dn_data_q    <= 8'd0;
         dn_region_q  <= REG_CPU;
      end else begin
         state_q      <= state_d;
         dl_q         <= dl_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         hold_q       <= hold_d;
         rom_valid_q  <= rom_valid_d;
         load_err_q   <= load_err_d;
         core_reset_q <= core_reset_d;
         dn_wr_q      <= dn_wr_d;
         dn_addr_q    <= dn_addr_d;
         dn_data_q    <= dn_data_d;
         dn_region_q  <= dn_region_d;
      end
   end

   assign bus.dn_wr      = dn_wr_q;
   assign bus.dn_addr    = dn_addr_q;
   assign bus.dn_data    = dn_data_q;
   assign bus.dn_region  = dn_region_q;
   assign bus.core_reset = core_reset_q;
   assign bus.rom_valid  = rom_valid_q;
   assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl with a small image geometry: directed scenarios plus
// randomized downloads checked against a length/overflow reference model.
module tb_rom_load_ctrl;
   localparam int LEN  = 8;
   localparam int HOLD = 4;
   localparam int GFX  = 4;
   localparam int SND  = 6;

   logic clk_sys = 1'b0;
   logic RESET   = 1'b0;

   rom_load_ctrl_if bus ();

   rom_load_ctrl #(
      .EXPECTED_LEN (17'd8),
      .RESET_HOLD   (16'd4),
      .GFX_BASE     (16'd4),
      .SND_BASE     (16'd6)
   ) dut (
      .clk_sys (clk_sys),
      .RESET   (RESET),
      .bus     (bus.slave)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   logic [24:0] q_addr[$];
   logic [7:0]  q_data[$];
   int          acc_cnt;
   bit          ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_region(input logic [24:0] a);
      if (a < GFX) return 2'd0;
      if (a < SND) return 2'd1;
      return 2'd2;
   endfunction

   // Drive one strobe (download already high); check the strobe one cycle later.
   task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      if (a < LEN) begin
         acc_cnt++;
         chk("dn_wr", bus.dn_wr, 1);
         chk("dn_addr", bus.dn_addr, a[15:0]);
         chk("dn_data", bus.dn_data, d);
         chk("dn_region", bus.dn_region, exp_region(a));
         $display("write addr=%0d data=%02h -> dn_wr=%0b region=%0d", a, d, bus.dn_wr, bus.dn_region);
      end else begin
         ovf = 1'b1;
         chk("dn_wr_dropped", bus.dn_wr, 0);
         $display("write addr=%0d data=%02h -> dropped, dn_wr=%0b", a, d, bus.dn_wr);
      end
   endtask

   // Current negedge is the first non-RUN cycle of a hold window.
   task automatic expect_hold_then_run();
      chk("core_reset_hold", bus.core_reset, 1);
      repeat (HOLD) begin
         @(negedge clk_sys);
         chk("core_reset_hold", bus.core_reset, 1);
      end
      @(negedge clk_sys);
      chk("core_reset_run", bus.core_reset, 0);
   endtask

   task automatic run_load(input bit gaps);
      bit good;
      acc_cnt = 0;
      ovf     = 1'b0;
      bus.ioctl_download = 1'b1;
      foreach (q_addr[i]) begin
         write_byte(q_addr[i], q_data[i]);
         if (i == 0) begin
            chk("core_reset_load", bus.core_reset, 1);
            chk("rom_valid_cleared", bus.rom_valid, 0);
            chk("load_err_cleared", bus.load_err, 0);
         end
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk_sys);
               chk("dn_wr_gap", bus.dn_wr, 0);
            end
         end
      end
      bus.ioctl_download = 1'b0;
      @(negedge clk_sys);
      chk("dn_wr_check", bus.dn_wr, 0);
      chk("core_reset_check", bus.core_reset, 1);
      @(negedge clk_sys);
      good = (acc_cnt == LEN) && !ovf;
      $display("load of %0d strobes: accepted=%0d overflow=%0b -> rom_valid=%0b load_err=%0b (expect valid=%0b)",
               q_addr.size(), acc_cnt, ovf, bus.rom_valid, bus.load_err, good);
      chk("rom_valid", bus.rom_valid, good);
      chk("load_err", bus.load_err, !good);
      if (good) begin
         expect_hold_then_run();
      end else begin
         repeat (6) begin
            chk("core_reset_error", bus.core_reset, 1);
            @(negedge clk_sys);
         end
      end
   endtask

   task automatic fill_seq(input int n, input logic [7:0] base);
      q_addr.delete();
      q_data.delete();
      for (int i = 0; i < n; i++) begin
         q_addr.push_back(25'(i));
         q_data.push_back(base + 8'(i));
      end
   endtask

   task automatic stray_writes(input int n, input logic exp_core_reset);
      repeat (n) begin
         bus.ioctl_wr   = 1'b1;
         bus.ioctl_addr = 25'($urandom_range(0, LEN - 1));
         bus.ioctl_dout = 8'($urandom);
         @(negedge clk_sys);
         chk("stray_dn_wr", bus.dn_wr, 0);
         chk("stray_core_reset", bus.core_reset, exp_core_reset);
         $display("stray write addr=%0d -> dn_wr=%0b core_reset=%0b", bus.ioctl_addr, bus.dn_wr, bus.core_reset);
      end
      bus.ioctl_wr = 1'b0;
   endtask

   initial begin
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      bus.user_reset     = 1'b0;

      #1 RESET = 1'b1;
      @(negedge clk_sys);
      chk("rst_core_reset", bus.core_reset, 1);
      chk("rst_dn_wr", bus.dn_wr, 0);
      chk("rst_dn_addr", bus.dn_addr, 0);
      chk("rst_dn_data", bus.dn_data, 0);
      chk("rst_dn_region", bus.dn_region, 0);
      chk("rst_rom_valid", bus.rom_valid, 0);
      chk("rst_load_err", bus.load_err, 0);
      @(negedge clk_sys);
      RESET = 1'b0;
      @(negedge clk_sys);

      stray_writes(3, 1'b1);

      fill_seq(8, 8'hA0);
      run_load(1'b0);

      stray_writes(3, 1'b0);

      // User reset from RUN, then a restart in the middle of the hold.
      bus.user_reset = 1'b1;
      @(negedge clk_sys);
      bus.user_reset = 1'b0;
      expect_hold_then_run();
      bus.user_reset = 1'b1;
      @(negedge clk_sys);
      bus.user_reset = 1'b0;
      chk("ureset_hold", bus.core_reset, 1);
      @(negedge clk_sys);
      chk("ureset_hold", bus.core_reset, 1);
      bus.user_reset = 1'b1;
      @(negedge clk_sys);
      bus.user_reset = 1'b0;
      $display("user reset restarted mid-hold");
      expect_hold_then_run();

      // Short load, then user reset is ignored in ERROR, then recovery.
      fill_seq(7, 8'h10);
      run_load(1'b0);
      bus.user_reset = 1'b1;
      @(negedge clk_sys);
      bus.user_reset = 1'b0;
      repeat (8) begin
         chk("error_core_reset", bus.core_reset, 1);
         @(negedge clk_sys);
      end
      fill_seq(8, 8'h20);
      run_load(1'b1);

      // Overflow: full image plus one out-of-range byte.
      fill_seq(8, 8'h30);
      q_addr.push_back(25'd8);
      q_data.push_back(8'h55);
      run_load(1'b0);

      // Randomized downloads.
      for (int it = 0; it < 8; it++) begin
         q_addr.delete();
         q_data.delete();
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < LEN; i++) begin
               q_addr.push_back(25'(i));
               q_data.push_back(8'($urandom));
            end
         end else begin
            int n;
            n = $urandom_range(5, 10);
            for (int i = 0; i < n; i++) begin
               q_addr.push_back(25'($urandom_range(0, LEN + 1)));
               q_data.push_back(8'($urandom));
            end
         end
         run_load(1'b1);
      end

      // Asynchronous reset in the middle of a load after three bytes.
      acc_cnt = 0;
      ovf     = 1'b0;
      bus.ioctl_download = 1'b1;
      write_byte(25'd0, 8'hC0);
      write_byte(25'd1, 8'hC1);
      write_byte(25'd2, 8'hC2);
      #2 RESET = 1'b1;
      #1;
      chk("async_core_reset", bus.core_reset, 1);
      chk("async_dn_wr", bus.dn_wr, 0);
      chk("async_dn_addr", bus.dn_addr, 0);
      chk("async_dn_data", bus.dn_data, 0);
      chk("async_dn_region", bus.dn_region, 0);
      chk("async_rom_valid", bus.rom_valid, 0);
      chk("async_load_err", bus.load_err, 0);
      $display("async reset mid-load -> core_reset=%0b dn_wr=%0b", bus.core_reset, bus.dn_wr);
      @(negedge clk_sys);
      RESET = 1'b0;
      for (int i = 3; i < 6; i++) begin
         bus.ioctl_wr   = 1'b1;
         bus.ioctl_addr = 25'(i);
         bus.ioctl_dout = 8'hC0 + 8'(i);
         @(negedge clk_sys);
         chk("post_reset_dn_wr", bus.dn_wr, 0);
         chk("post_reset_core_reset", bus.core_reset, 1);
      end
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_download = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk("post_reset_idle", bus.core_reset, 1);
      fill_seq(8, 8'hD0);
      run_load(1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter EXPECTED_LEN, default 17'h10000: exact byte count of a valid ROM image.
REQ-002 SHALL have parameter RESET_HOLD, default 16'd1024: clk_sys cycles the core reset is held after a valid load or user reset.
REQ-003 SHALL have parameter GFX_BASE, default 16'h4000: first address of the graphics region.
REQ-004 SHALL have parameter SND_BASE, default 16'h5000: first address of the sound/other region.
REQ-005 clk_sys  in  1  single clock for all logic.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 ioctl_download  in  1  HPS download window active.
REQ-008 ioctl_wr  in  1  one-cycle byte write strobe from HPS.
REQ-009 ioctl_addr  in  25  byte address of the write.
REQ-010 ioctl_dout  in  8  byte data of the write.
REQ-011 user_reset  in  1  synchronous reset request (OSD reset or user button).
REQ-012 dn_addr  out  16  registered ROM write address.
REQ-013 dn_data  out  8  registered ROM write data.
REQ-014 dn_wr  out  1  one-cycle ROM write strobe.
REQ-015 dn_region  out  2  region of the current write: 0 CPU, 1 GFX, 2 other.
REQ-016 core_reset  out  1  registered reset to the game core.
REQ-017 rom_valid  out  1  last completed download was good.
REQ-018 load_err  out  1  last completed download was bad.

Function
REQ-019 SHALL implement states IDLE, LOAD, CHECK, HOLD, RUN, ERROR.
REQ-020 SHALL detect the ioctl_download rising and falling edges with a one-cycle registered copy.
REQ-021 SHALL go IDLE->LOAD, RUN->LOAD, HOLD->LOAD, and ERROR->LOAD on an ioctl_download rising edge, clearing byte count and overflow flag, rom_valid and load_err.
REQ-022 LOAD: each ioctl_wr with ioctl_download=1 and ioctl_addr < EXPECTED_LEN SHALL give dn_wr=1 exactly one cycle later, with dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout captured on the strobe cycle.
REQ-023 LOAD: on such a write, dn_region SHALL be 0 if addr < GFX_BASE, 1 if addr < SND_BASE, else 2, and SHALL be valid with dn_wr.
REQ-024 A write with ioctl_addr >= EXPECTED_LEN SHALL be dropped (no dn_wr) and SHALL set the overflow flag.
REQ-025 The byte count SHALL be 17 bits and SHALL saturate at 17'h1FFFF, never wrapping.
REQ-026 The byte count SHALL increment only on accepted writes.
REQ-027 ioctl_wr while ioctl_download=0 SHALL be ignored in every state.
REQ-028 ioctl_wr on the same cycle as the download rising edge SHALL be accepted and counted.
REQ-029 LOAD SHALL go to CHECK on the ioctl_download falling edge.
REQ-030 CHECK SHALL last one cycle: if count==EXPECTED_LEN and no overflow, go to HOLD with rom_valid=1; otherwise go to ERROR with load_err=1.
REQ-031 HOLD SHALL load a counter with RESET_HOLD on entry, decrement it each cycle, and go to RUN the cycle after it reaches 0.
REQ-032 RUN: user_reset=1 SHALL go to HOLD and reload the counter.
REQ-033 HOLD: user_reset=1 SHALL reload the counter.
REQ-034 IDLE, LOAD, ERROR: user_reset SHALL be ignored.
REQ-035 core_reset SHALL be 0 only in RUN and SHALL be 1 in all other states.
REQ-036 core_reset SHALL rise on the cycle after a download rising edge in RUN.
REQ-037 dn_wr SHALL never be asserted outside LOAD, except for the trailing strobe one cycle after the final accepted write.

Reset
REQ-038 RESET SHALL asynchronously force state=IDLE, core_reset=1, dn_wr=0, dn_addr=0, dn_data=0, dn_region=0, rom_valid=0, load_err=0, count=0, overflow=0, hold counter=0.
REQ-039 RESET asserted mid-LOAD SHALL abort the load, and no further dn_wr SHALL occur until a new download rising edge.

Verification (EXPECTED_LEN=8, RESET_HOLD=4, GFX_BASE=4, SND_BASE=6)
REQ-040 Good load: download of 8 bytes at addr 0..7, data A0..A7 -> eight dn_wr pulses with matching addr/data, dn_region 0,0,0,0,1,1,2,2, rom_valid=1, core_reset=1 for CHECK + 5 HOLD cycles, then 0.
REQ-041 Short load: 7 bytes -> load_err=1, rom_valid=0, core_reset stays 1 indefinitely, and a subsequent good load recovers to RUN.
REQ-042 Overflow: 8 bytes plus a write at addr 8 -> no dn_wr for addr 8, load_err=1.
REQ-043 Stray writes: ioctl_wr pulses with ioctl_download=0 in IDLE and RUN -> no dn_wr, count unchanged, core_reset unaffected.
REQ-044 User reset: user_reset pulsed in RUN -> core_reset=1 next cycle, held 5 cycles, then 0; pulse again mid-HOLD -> hold restarts.
REQ-045 Async reset mid-LOAD after 3 bytes -> all outputs at reset values immediately, and state=IDLE after release.
